// File: rtl/fifo_axis_reader_if.sv
// Bundles the FIFO read-port signals and the AXI4-Stream master signals of fifo_axis_reader.
// With FIFO_AXIS_READER_TUSER_EN defined, the bundle also carries m_axis_tuser (start-of-packet).
interface fifo_axis_reader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) ();
    logic [DATA_WIDTH-1:0] Fifo_data_in;
    logic                  Fifo_empty_in;
    logic                  Fifo_read_en_out;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
`ifdef FIFO_AXIS_READER_TUSER_EN
    logic                  m_axis_tuser;
`endif
    logic [CNT_WIDTH-1:0]  Beat_cnt_out;

    modport master (
        input  Fifo_data_in, Fifo_empty_in, m_axis_tready,
        output Fifo_read_en_out, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
`ifdef FIFO_AXIS_READER_TUSER_EN
        output m_axis_tuser,
`endif
        output Beat_cnt_out
    );

    modport slave (
        output Fifo_data_in, Fifo_empty_in, m_axis_tready,
        input  Fifo_read_en_out, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
`ifdef FIFO_AXIS_READER_TUSER_EN
        input  m_axis_tuser,
`endif
        input  Beat_cnt_out
    );
endinterface

// File: rtl/fifo_axis_reader.sv
// Drains a 1-cycle-latency FIFO read port into an AXI4-Stream master, framed into PACKET_LEN-beat packets.
// Optional start-of-packet m_axis_tuser output is enabled by defining FIFO_AXIS_READER_TUSER_EN.
module fifo_axis_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACKET_LEN = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Flush_in,
    fifo_axis_reader_if.master   bus
);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PACKET_LEN - 1);

    logic                  started_q,  started_d;
    logic                  inflight_q, inflight_d;
    logic                  head_vld_q, head_vld_d;
    logic                  tail_vld_q, tail_vld_d;
    logic [DATA_WIDTH-1:0] head_q,     head_d;
    logic [DATA_WIDTH-1:0] tail_q,     tail_d;
    logic [CNT_WIDTH-1:0]  beat_q,     beat_d;
    logic                  tlast_q,    tlast_d;
`ifdef FIFO_AXIS_READER_TUSER_EN
    logic                  tuser_q,    tuser_d;
`endif
    logic                  pop_c;
    logic [1:0]            occ_after_pop_c;
    logic                  rd_en_c;

    // Issue, buffer, and framing next-state logic
    always_comb begin
        started_d  = 1'b1;
        inflight_d = 1'b0;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        head_d     = head_q;
        tail_d     = tail_q;
        beat_d     = beat_q;

        pop_c           = head_vld_q & bus.m_axis_tready;
        occ_after_pop_c = {1'b0, head_vld_q} + {1'b0, tail_vld_q} - {1'b0, pop_c};
        // In-flight word lands next cycle, so it already owns a slot
        rd_en_c = started_q & ~Flush_in & ~bus.Fifo_empty_in
                & ((occ_after_pop_c + {1'b0, inflight_q}) < 2'd2);
        inflight_d = rd_en_c;

        if (pop_c) begin
            head_vld_d = tail_vld_q;
            head_d     = tail_q;
            tail_vld_d = 1'b0;
            beat_d     = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_WIDTH'(1);
        end

        if (inflight_q) begin
            if (!head_vld_d) begin
                head_vld_d = 1'b1;
                head_d     = bus.Fifo_data_in;
            end else begin
                tail_vld_d = 1'b1;
                tail_d     = bus.Fifo_data_in;
            end
        end

        if (Flush_in) begin
            inflight_d = 1'b0;
            head_vld_d = 1'b0;
            tail_vld_d = 1'b0;
            beat_d     = '0;
        end

        tlast_d = head_vld_d & (beat_d == LAST_BEAT);
`ifdef FIFO_AXIS_READER_TUSER_EN
        tuser_d = head_vld_d & (beat_d == '0);
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            started_q  <= 1'b0;
            inflight_q <= 1'b0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= '0;
            tlast_q    <= 1'b0;
`ifdef FIFO_AXIS_READER_TUSER_EN
            tuser_q    <= 1'b0;
`endif
        end else begin
            started_q  <= started_d;
            inflight_q <= inflight_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
            tlast_q    <= tlast_d;
`ifdef FIFO_AXIS_READER_TUSER_EN
            tuser_q    <= tuser_d;
`endif
        end
    end

    assign bus.Fifo_read_en_out = rd_en_c;
    assign bus.m_axis_tdata     = head_q;
    assign bus.m_axis_tvalid    = head_vld_q;
    assign bus.m_axis_tlast     = tlast_q;
`ifdef FIFO_AXIS_READER_TUSER_EN
    assign bus.m_axis_tuser     = tuser_q;
`endif
    assign bus.Beat_cnt_out     = beat_q;
endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader: models a registered-read FIFO and checks the framed stream.
module tb_fifo_axis_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned PL = 4;
    localparam int unsigned CW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic [CW-1:0] beat;
    } exp_t;

    logic Clk      = 1'b0;
    logic Rst_n    = 1'b0;
    logic Flush_in = 1'b0;
    logic glitch   = 1'b0;
    logic acc_pre  = 1'b0;
    int   fifo_n   = 0;
    int   pop_cnt  = 0;
    int   exp_beat = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];

    fifo_axis_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_axis_reader #(.DATA_WIDTH(DW), .PACKET_LEN(PL), .CNT_WIDTH(CW)) u_dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Flush_in (Flush_in),
        .bus      (bus.master)
    );

    always #5 Clk = ~Clk;

    assign bus.Fifo_empty_in = glitch | (fifo_n == 0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic add_exp(input logic [DW-1:0] b);
        exp_t e;
        e.data = b;
        e.beat = CW'(exp_beat);
        e.last = (exp_beat == int'(PL) - 1);
        e.user = (exp_beat == 0);
        exp_q.push_back(e);
        exp_beat = (exp_beat + 1) % int'(PL);
    endtask

    task automatic push_word(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        fifo_n++;
        add_exp(b);
    endtask

    // Words the DUT already pulled are gone; the rest restart a fresh packet
    task automatic rebuild();
        exp_q.delete();
        exp_beat = 0;
        foreach (fifo_q[i]) add_exp(fifo_q[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < max_cycles) begin
            tick(1);
            k++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // FIFO read acceptance is sampled just before the edge, data appears just after it
    initial forever begin
        @(negedge Clk);
        #4;
        acc_pre = bus.Fifo_read_en_out & ~bus.Fifo_empty_in;
    end

    initial begin
        logic acc_now;
        bus.Fifo_data_in = '0;
        forever begin
            @(posedge Clk);
            acc_now = acc_pre;
            #1;
            if (acc_now && fifo_q.size() != 0) begin
                bus.Fifo_data_in = fifo_q.pop_front();
                fifo_n--;
                pop_cnt++;
            end
        end
    end

    // Stream monitor: every handshake is checked against the scoreboard head
    initial forever begin
        @(negedge Clk);
        if (Rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("sb_tdata", 32'(bus.m_axis_tdata), 32'(e.data));
                check_eq("sb_tlast", 32'(bus.m_axis_tlast), 32'(e.last));
                check_eq("sb_beat",  32'(bus.Beat_cnt_out), 32'(e.beat));
`ifdef FIFO_AXIS_READER_TUSER_EN
                check_eq("sb_tuser", 32'(bus.m_axis_tuser), 32'(e.user));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_axis_tready = 1'b1;

        // 1: reset values with a non-empty FIFO, then first-read and first-beat latency
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        tick(2);
        #3;
        check_eq("rst_rd_en",  32'(bus.Fifo_read_en_out), 32'd0);
        check_eq("rst_tvalid", 32'(bus.m_axis_tvalid),    32'd0);
        check_eq("rst_tlast",  32'(bus.m_axis_tlast),     32'd0);
        check_eq("rst_tdata",  32'(bus.m_axis_tdata),     32'd0);
        check_eq("rst_beat",   32'(bus.Beat_cnt_out),     32'd0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(negedge Clk); check_eq("t1_rd_c0",   32'(bus.Fifo_read_en_out), 32'd0);
        @(negedge Clk); check_eq("t1_rd_c1",   32'(bus.Fifo_read_en_out), 32'd1);
        @(negedge Clk); check_eq("t1_vld_c2",  32'(bus.m_axis_tvalid),    32'd0);
        @(negedge Clk); check_eq("t1_vld_c3",  32'(bus.m_axis_tvalid),    32'd1);
                        check_eq("t1_data_c3", 32'(bus.m_axis_tdata),     32'h11);
        @(negedge Clk); check_eq("t1_vld_c4",  32'(bus.m_axis_tvalid),    32'd1);
        @(negedge Clk); check_eq("t1_vld_c5",  32'(bus.m_axis_tvalid),    32'd1);
        @(negedge Clk); check_eq("t1_vld_c6",  32'(bus.m_axis_tvalid),    32'd0);
                        check_eq("t1_rd_idle", 32'(bus.Fifo_read_en_out), 32'd0);
        tick(1);

        // 2: flush restarts the packet, then 10 words framed into 4-beat packets
        Flush_in = 1'b1;
        tick(1);
        Flush_in = 1'b0;
        rebuild();
        check_eq("t2_flush_beat", 32'(bus.Beat_cnt_out), 32'd0);
        for (int i = 0; i < 10; i++) push_word(8'(i));
        drain("t2_drain", 200);
        check_eq("t2_beat_end", 32'(bus.Beat_cnt_out), 32'd2);

        // 3: backpressure with a full FIFO, then a 32-word sweep
        bus.m_axis_tready = 1'b0;
        pop_cnt = 0;
        for (int i = 0; i < 32; i++) push_word(8'(8'h40 + i));
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (i >= 3) check_eq("t3_hold_data", 32'(bus.m_axis_tdata), 32'h40);
        end
        check_eq("t3_reads", 32'(pop_cnt), 32'd2);
        check_eq("t3_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        tick(1);
        bus.m_axis_tready = 1'b1;
        drain("t3_drain", 400);

        // 4: empty rises mid-cycle while a read is being requested
        tick(2);
        pop_cnt = 0;
        push_word(8'h77);
        @(negedge Clk);
        check_eq("t4_rd_req", 32'(bus.Fifo_read_en_out), 32'd1);
        glitch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_eq("t4_no_vld", 32'(bus.m_axis_tvalid), 32'd0);
        end
        check_eq("t4_no_pop", 32'(pop_cnt), 32'd0);
        tick(1);
        glitch = 1'b0;
        drain("t4_drain", 50);

        // 5: flush mid-stream at beat 3 with a read in flight
        begin
            logic found = 1'b0;
            for (int i = 0; i < 20; i++) push_word(8'(8'h80 + i));
            for (int k = 0; k < 60 && !found; k++) begin
                tick(1);
                if (bus.Beat_cnt_out == CW'(3) && bus.m_axis_tvalid && bus.m_axis_tdata != 8'h80)
                    found = 1'b1;
            end
            check_eq("t5_sync", 32'(found), 32'd1);
        end
        Flush_in = 1'b1;
        tick(1);
        Flush_in = 1'b0;
        check_eq("t5_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_eq("t5_beat",   32'(bus.Beat_cnt_out),  32'd0);
        rebuild();
        drain("t5_drain", 200);

        // 6: asynchronous reset mid-packet under backpressure
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'(8'hA0 + i));
        tick(6);
        check_eq("t6_pre_vld",  32'(bus.m_axis_tvalid), 32'd1);
        check_eq("t6_pre_beat", 32'(bus.Beat_cnt_out),  32'd2);
        #2;
        Rst_n = 1'b0;
        #1;
        check_eq("t6_rst_vld",   32'(bus.m_axis_tvalid),    32'd0);
        check_eq("t6_rst_data",  32'(bus.m_axis_tdata),     32'd0);
        check_eq("t6_rst_beat",  32'(bus.Beat_cnt_out),     32'd0);
        check_eq("t6_rst_tlast", 32'(bus.m_axis_tlast),     32'd0);
        check_eq("t6_rst_rd",    32'(bus.Fifo_read_en_out), 32'd0);
`ifdef FIFO_AXIS_READER_TUSER_EN
        check_eq("t6_rst_tuser", 32'(bus.m_axis_tuser),     32'd0);
`endif
        tick(2);
        Rst_n = 1'b1;
        rebuild();
        bus.m_axis_tready = 1'b1;
        drain("t6_drain", 100);
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
